// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequencer for a serial-operand multiplier core and its product serializer
// Define MULT_SEQ_TIMEOUT_EN to build the watchdog counter and the ERR state.
module mult_seq_ctrl #(
  parameter int N_IN    = 12,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic sin_en,
  output logic mul_go,
  input  logic mul_done,
  output logic sz,
  input  logic fz,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

  if (N_IN < 1 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_param
    $error("mult_seq_ctrl: N_IN must be >= 1 and TIMEOUT within 2..255");
  end

`ifdef MULT_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, SHIFT_IN, MULT, UNLOAD_REQ, UNLOAD, DONE, ERR} state_t;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wdog, wdog_n;
`else
  typedef enum logic [2:0] {IDLE, SHIFT_IN, MULT, UNLOAD_REQ, UNLOAD, DONE} state_t;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic             start_q, hist_vld, start_edge, exit_ok, busy_n;

  // hist_vld stays low for the first cycle after reset so a start level held
  // across reset release is not mistaken for a rising edge
  assign start_edge = start & ~start_q & hist_vld;

  always_comb begin
    state_n = state;
    exit_ok = 1'b0;
    case (state)
      IDLE:       if (start_edge) state_n = SHIFT_IN;
      SHIFT_IN:   if (bit_cnt == CNT_LAST) state_n = MULT;
      MULT: begin
        // mul_go is still high during the launch cycle, so mul_done is ignored there
        exit_ok = mul_done & ~mul_go;
        if (exit_ok) state_n = UNLOAD_REQ;
      end
      UNLOAD_REQ: begin
        exit_ok = fz;
        if (exit_ok) state_n = UNLOAD;
      end
      UNLOAD: begin
        exit_ok = ~fz;
        if (exit_ok) state_n = DONE;
      end
      DONE:       state_n = IDLE;
`ifdef MULT_SEQ_TIMEOUT_EN
      ERR:        if (start_edge) state_n = SHIFT_IN;
`endif
      default:    state_n = IDLE;
    endcase
`ifdef MULT_SEQ_TIMEOUT_EN
    // a met exit condition wins over an expiring watchdog
    if ((state == MULT || state == UNLOAD_REQ || state == UNLOAD) && !exit_ok && wdog == WD_LAST)
      state_n = ERR;
`endif
    bit_cnt_n = (state == SHIFT_IN && state_n == SHIFT_IN) ? bit_cnt + 1'b1 : '0;
  end

`ifdef MULT_SEQ_TIMEOUT_EN
  always_comb begin
    wdog_n = '0;
    if (state_n == state && (state == MULT || state == UNLOAD_REQ || state == UNLOAD))
      wdog_n = wdog + 8'd1;
  end

  assign busy_n = (state_n != IDLE) && (state_n != ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog <= '0;
      err  <= 1'b0;
    end else begin
      wdog <= wdog_n;
      err  <= (state_n == ERR);
    end
  end
`else
  assign busy_n = (state_n != IDLE);
  assign err    = 1'b0;
`endif

  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      start_q  <= 1'b0;
      hist_vld <= 1'b0;
      sin_en   <= 1'b0;
      mul_go   <= 1'b0;
      sz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      start_q  <= start;
      hist_vld <= 1'b1;
      sin_en   <= (state_n == SHIFT_IN);
      mul_go   <= (state_n == MULT) && (state != MULT);
      sz       <= (state_n == UNLOAD_REQ);
      busy     <= busy_n;
      done     <= (state_n == DONE);
    end
  end

endmodule
